// File: rtl/hex_scan_scheduler.sv
// Time-multiplexed scan scheduler for a shared hex seven-segment decoder.
// Shadow digit state is committed to the active set only at frame boundaries.
module hex_scan_scheduler #(
  parameter int NUM_DIGITS = 4,
  parameter int DIG_W      = 2,
  parameter int DIV        = 50000,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DIG_W-1:0]      wr_digit,
  input  logic [3:0]            wr_value,
  input  logic                  wr_blank,
  output logic [3:0]            dec_nibble,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIG_W-1:0] LAST_IDX = DIG_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    GUARD
  } state_t;

  state_t state_q, state_d;
  logic [DIG_W-1:0] index_q, index_d;
  logic [CNT_W-1:0] counter_q, counter_d;

  logic [NUM_DIGITS-1:0][3:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]      shadow_blank_q, shadow_blank_d;
  logic [NUM_DIGITS-1:0][3:0] active_val_q, active_val_d;
  logic [NUM_DIGITS-1:0]      active_blank_q, active_blank_d;

  logic [3:0]            dec_nibble_q, dec_nibble_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic                  frame_done_q, frame_done_d;
  logic                  wr_ready_q, wr_ready_d;

  logic             wrap;
  logic             wr_accept;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] scan_idx;

  assign wrap      = (index_q == LAST_IDX);
  assign wr_accept = wr_valid & wr_ready_q;
  assign wr_idx    = wr_digit[IDX_W-1:0];
  assign scan_idx  = index_d[IDX_W-1:0];

  // Out-of-range digit indices complete the handshake but touch nothing.
  always_comb begin
    shadow_val_d   = shadow_val_q;
    shadow_blank_d = shadow_blank_q;
    if (wr_accept && (32'(wr_digit) < NUM_DIGITS)) begin
      shadow_val_d[wr_idx]   = wr_value;
      shadow_blank_d[wr_idx] = wr_blank;
    end
  end

  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    counter_d      = counter_q;
    active_val_d   = active_val_q;
    active_blank_d = active_blank_q;

    if (!enable) begin
      state_d   = IDLE;
      index_d   = '0;
      counter_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = SCAN;
          index_d   = '0;
          counter_d = '0;
        end
        SCAN: begin
          if (counter_q == CNT_LAST) begin
            state_d   = GUARD;
            counter_d = '0;
          end else begin
            counter_d = counter_q + CNT_W'(1);
          end
        end
        GUARD: begin
          state_d = SCAN;
          index_d = wrap ? '0 : index_q + DIG_W'(1);
        end
        default: begin
          state_d   = IDLE;
          index_d   = '0;
          counter_d = '0;
        end
      endcase
    end

    // Idle tracks the shadow continuously; while scanning it only commits after the last guard.
    if ((state_q == IDLE) || ((state_q == GUARD) && wrap)) begin
      active_val_d   = shadow_val_q;
      active_blank_d = shadow_blank_q;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    dec_nibble_d = '0;
    dig_sel_d    = '0;
    frame_done_d = 1'b0;
    wr_ready_d   = 1'b1;
    unique case (state_d)
      SCAN: begin
        if (!active_blank_d[scan_idx]) begin
          dec_nibble_d = active_val_d[scan_idx];
          dig_sel_d    = SEL_ONE << index_d;
        end
      end
      GUARD: begin
        if ((state_q == SCAN) && wrap) begin
          frame_done_d = 1'b1;
          wr_ready_d   = 1'b0;
        end
      end
      default: begin
        dec_nibble_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      index_q        <= '0;
      counter_q      <= '0;
      shadow_val_q   <= '0;
      shadow_blank_q <= '1;
      active_val_q   <= '0;
      active_blank_q <= '1;
      dec_nibble_q   <= '0;
      dig_sel_q      <= '0;
      frame_done_q   <= 1'b0;
      wr_ready_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      counter_q      <= counter_d;
      shadow_val_q   <= shadow_val_d;
      shadow_blank_q <= shadow_blank_d;
      active_val_q   <= active_val_d;
      active_blank_q <= active_blank_d;
      dec_nibble_q   <= dec_nibble_d;
      dig_sel_q      <= dig_sel_d;
      frame_done_q   <= frame_done_d;
      wr_ready_q     <= wr_ready_d;
    end
  end

  assign dec_nibble = dec_nibble_q;
  assign dig_sel    = dig_sel_q;
  assign frame_done = frame_done_q;
  assign wr_ready   = wr_ready_q;

endmodule

// File: tb/tb_hex_scan_scheduler.sv
// Scoreboard bench for hex_scan_scheduler: a frame-position model predicts
// every cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_hex_scan_scheduler;

  localparam int NUM_DIGITS = 4;
  localparam int DIG_W      = 3;
  localparam int DIV        = 4;
  localparam int CNT_W      = 8;
  localparam int SLOT       = DIV + 1;
  localparam int FRAME      = NUM_DIGITS * SLOT;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  enable;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DIG_W-1:0]      wr_digit;
  logic [3:0]            wr_value;
  logic                  wr_blank;
  logic [3:0]            dec_nibble;
  logic [NUM_DIGITS-1:0] dig_sel;
  logic                  frame_done;

  typedef struct packed {
    logic [3:0]            nib;
    logic [NUM_DIGITS-1:0] sel;
    logic                  fd;
    logic                  rdy;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  bit running;
  int pos;
  int sh_val[NUM_DIGITS];
  bit sh_blank[NUM_DIGITS];
  int ac_val[NUM_DIGITS];
  bit ac_blank[NUM_DIGITS];
  bit m_ready;
  bit last_accept;

  hex_scan_scheduler #(
    .NUM_DIGITS(NUM_DIGITS),
    .DIG_W(DIG_W),
    .DIV(DIV),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_digit(wr_digit),
    .wr_value(wr_value),
    .wr_blank(wr_blank),
    .dec_nibble(dec_nibble),
    .dig_sel(dig_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    running     = 1'b0;
    pos         = 0;
    m_ready     = 1'b1;
    last_accept = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sh_val[i]   = 0;
      sh_blank[i] = 1'b1;
      ac_val[i]   = 0;
      ac_blank[i] = 1'b1;
    end
  endtask

  // Predict the outputs seen after the coming edge from the frame position.
  task automatic model_edge(output exp_t e);
    int slot;
    int off;
    if (reset) begin
      model_reset();
    end else begin
      last_accept = wr_valid && m_ready;
      if (!enable) begin
        running = 1'b0;
        pos     = 0;
      end else if (!running) begin
        running  = 1'b1;
        pos      = 0;
        ac_val   = sh_val;
        ac_blank = sh_blank;
      end else begin
        pos++;
        if (pos == FRAME) begin
          pos      = 0;
          ac_val   = sh_val;
          ac_blank = sh_blank;
        end
      end
      if (last_accept && (int'(wr_digit) < NUM_DIGITS)) begin
        sh_val[int'(wr_digit)]   = int'(wr_value);
        sh_blank[int'(wr_digit)] = wr_blank;
      end
    end
    e = '{nib: 4'h0, sel: '0, fd: 1'b0, rdy: 1'b1};
    if (running) begin
      slot = pos / SLOT;
      off  = pos % SLOT;
      if (off == DIV) begin
        e.fd  = (slot == NUM_DIGITS - 1);
        e.rdy = !e.fd;
      end else if (!ac_blank[slot]) begin
        e.nib = 4'(ac_val[slot]);
        e.sel = NUM_DIGITS'(1) << slot;
      end
    end
    m_ready = e.rdy;
  endtask

  task automatic apply_stimulus(input int cycles = 1);
    exp_t e;
    for (int c = 0; c < cycles; c++) begin
      model_edge(e);
      @(posedge clk);
      #1;
      exp_q.push_back(e);
    end
  endtask

  task automatic write_digit(input int d, input int v, input bit b);
    int tries;
    wr_valid = 1'b1;
    wr_digit = DIG_W'(d);
    wr_value = 4'(v);
    wr_blank = b;
    tries    = 0;
    do begin
      apply_stimulus();
      tries++;
    end while (!last_accept && tries < 8);
    if (!last_accept) begin
      errors++;
      $display("[TB] FAIL write_timeout: digit %0d not accepted after %0d cycles", d, tries);
    end
    wr_valid = 1'b0;
  endtask

  task automatic run_to_pos(input int target);
    int budget;
    budget = 0;
    while (!(running && pos == target) && budget < 4 * FRAME) begin
      apply_stimulus();
      budget++;
    end
    if (!(running && pos == target)) begin
      errors++;
      $display("[TB] FAIL pos_timeout: frame position %0d never reached", target);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, compared half a cycle after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("dec_nibble", int'(dec_nibble), int'(e.nib));
        check_output("dig_sel", int'(dig_sel), int'(e.sel));
        check_output("frame_done", int'(frame_done), int'(e.fd));
        check_output("wr_ready", int'(wr_ready), int'(e.rdy));
      end
    end
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    wr_valid = 1'b0;
    wr_digit = '0;
    wr_value = '0;
    wr_blank = 1'b0;
    model_reset();
    #1;
    check_output("reset_dec_nibble", int'(dec_nibble), 0);
    check_output("reset_dig_sel", int'(dig_sel), 0);
    check_output("reset_frame_done", int'(frame_done), 0);
    check_output("reset_wr_ready", int'(wr_ready), 1);
    apply_stimulus(2);
    reset = 1'b0;
    apply_stimulus(2);

    // All digits blank after reset: dark scan, frame_done every FRAME cycles.
    enable = 1'b1;
    apply_stimulus(2 * FRAME + 5);

    // Load 1,2,A,F while idle, then scan.
    enable = 1'b0;
    apply_stimulus(2);
    write_digit(0, 4'h1, 1'b0);
    write_digit(1, 4'h2, 1'b0);
    write_digit(2, 4'hA, 1'b0);
    write_digit(3, 4'hF, 1'b0);
    apply_stimulus(2);
    enable = 1'b1;
    apply_stimulus(FRAME);

    // Mid-frame write to digit 0 while digit 1 scans.
    run_to_pos(SLOT + 1);
    write_digit(0, 4'h7, 1'b0);
    apply_stimulus(FRAME + 4);

    // Write held across the commit guard cycle.
    run_to_pos(FRAME - 1);
    write_digit(1, 4'h5, 1'b0);
    apply_stimulus(2 * FRAME);

    // Blank digit 2; out-of-range digit index must be a no-op.
    write_digit(2, 4'h9, 1'b1);
    write_digit(5, 4'h3, 1'b0);
    apply_stimulus(2 * FRAME);

    // Randomised traffic with occasional enable drops.
    for (int i = 0; i < 400; i++) begin
      if (!wr_valid || last_accept) begin
        wr_valid = ($urandom_range(0, 3) == 0);
        wr_digit = DIG_W'($urandom_range(0, 7));
        wr_value = 4'($urandom);
        wr_blank = ($urandom_range(0, 3) == 0);
      end
      enable = ($urandom_range(0, 39) != 0);
      apply_stimulus();
    end
    wr_valid = 1'b0;

    // Enable drop mid-slot, then asynchronous reset mid-frame.
    enable = 1'b1;
    apply_stimulus(2);
    run_to_pos(SLOT + 2);
    enable = 1'b0;
    apply_stimulus(2);
    enable = 1'b1;
    apply_stimulus(8);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_output("async_dec_nibble", int'(dec_nibble), 0);
    check_output("async_dig_sel", int'(dig_sel), 0);
    check_output("async_frame_done", int'(frame_done), 0);
    check_output("async_wr_ready", int'(wr_ready), 1);
    model_reset();
    apply_stimulus(2);
    reset = 1'b0;
    apply_stimulus(FRAME + 5);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_scan_scheduler.md
Name: hex_scan_scheduler

Overview:
- Time-multiplexes a single shared 4-bit-to-seven-segment decoder across NUM_DIGITS display digits.
- Holds per-digit nibble and blank state in shadow registers, written through a valid/ready port. Shadow state is committed to active registers only at frame boundaries, so a frame never shows a mix of old and new values.
- Drives the decoder's 4-bit select input and a one-hot digit enable.
- Sits between the lab top level (SW/KEY-driven writers) and the seven-segment decoder instance.

Parameters:
- NUM_DIGITS, 4, digits scanned per frame (2..8).
- DIG_W, 2, width of the digit index; 2**DIG_W >= NUM_DIGITS.
- DIV, 50000, clock cycles each digit is driven per slot (>=2).
- CNT_W, 16, divider counter width; 2**CNT_W > DIV.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = scanning, 0 = display dark/idle.
- wr_valid  input  1  write request.
- wr_ready  output  1  write accepted when wr_valid & wr_ready at a rising edge.
- wr_digit  input  DIG_W  target digit index.
- wr_value  input  4  nibble for the target digit.
- wr_blank  input  1  1 = target digit blanked.
- dec_nibble  output  4  drives the shared decoder S input.
- dig_sel  output  NUM_DIGITS  one-hot digit enable, active-high.
- frame_done  output  1  one-cycle pulse at end of each frame.

Behaviour:
- All outputs are registered. Internal clock is clk; reset is asynchronous, active-high.
- Reset values:
  - state=IDLE, index=0, counter=0.
  - All shadow/active values = 0; all shadow/active blank bits = 1.
  - dec_nibble=0, dig_sel=0, frame_done=0, wr_ready=1.
- FSM states: IDLE, SCAN, GUARD.
- IDLE:
  - dig_sel=0, dec_nibble=0.
  - active <= shadow every cycle.
  - enable=1 sampled -> SCAN next cycle with index=0, counter=0.
- SCAN:
  - dec_nibble = active value[index].
  - dig_sel = one-hot(index), or 0 if active blank[index]=1 (dec_nibble is then 0).
  - counter increments each cycle; when counter==DIV-1 -> GUARD, counter <= 0.
  - Each slot is exactly DIV cycles.
- GUARD (exactly 1 cycle):
  - dig_sel=0, dec_nibble=0 (anti-ghosting dead time).
  - index <= index+1, or 0 if index==NUM_DIGITS-1 (wrap).
  - On wrap only: frame_done=1 for this cycle, active <= shadow at the end of this cycle, and wr_ready=0 for this cycle.
  - GUARD -> SCAN.
- Frame period = NUM_DIGITS*(DIV+1) cycles.
- Write handshake:
  - Accept = wr_valid & wr_ready at a rising edge; it updates shadow[wr_digit] value and blank.
  - wr_digit >= NUM_DIGITS: the write is accepted (handshake completes) and has no effect.
  - A write stalled by wr_ready=0 stays pending; the writer must hold wr_valid and its data stable until accepted.
  - Writes accepted after a commit become visible at the next commit.
- Multiple writes to the same digit within a frame: last write wins.
- Simultaneous events:
  - Write accept and commit never coincide, because wr_ready=0 in the commit cycle.
  - enable=0 sampled in any state -> IDLE next cycle; index and counter reset to 0; no frame_done; shadow kept.
- Reset asserted mid-frame forces the reset values immediately (asynchronous), discarding shadow contents.
- Output latency: a state transition sampled at edge t is reflected on dig_sel/dec_nibble after edge t.

Test Plan:
- Reset, then enable=1 with DIV=4, NUM_DIGITS=4 -> dig_sel=0 throughout (all digits blanked by reset); frame_done pulses every 20 cycles.
- While idle, write digits 0..3 = 1,2,A,F with blank=0, then enable=1 -> dec_nibble/dig_sel sequence 1/0001 (4 cycles), 0/0000 (guard), 2/0010, 0/0000, A/0100, 0/0000, F/1000, then guard with frame_done=1.
- Mid-frame, while digit 1 is scanning, write digit 0=7 -> current frame still shows 1 on digit 0; next frame shows 7.
- Hold wr_valid=1 targeting the commit guard cycle -> wr_ready=0 in that cycle; the write is accepted on the following edge and first appears in the frame after next.
- Write wr_digit=2 with wr_blank=1 -> in the next frame the slot-2 window has dig_sel=0000 and dec_nibble=0 for the full 4 cycles; other digits are unaffected.
- Drop enable mid-slot, then assert reset mid-frame -> dig_sel=0 the cycle after enable falls with no frame_done; reset returns all outputs to reset values immediately, without waiting for a clock edge.
